// File: rtl/adder_pkg.sv
// Shared datapath width and FSM state encoding for the adder accumulator.
package adder_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/carry_select_adder.sv
// 32-bit carry-select adder: each 8-bit block precomputes both carry-in cases
// and the incoming block carry picks the result.
module carry_select_adder
    import adder_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o
);

    localparam int BLOCK_W = 8;
    localparam int NBLK    = DATA_W / BLOCK_W;

    logic [NBLK-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLOCK_W:0] sum0;
        logic [BLOCK_W:0] sum1;

        assign sum0 = {1'b0, a_i[g*BLOCK_W +: BLOCK_W]} + {1'b0, b_i[g*BLOCK_W +: BLOCK_W]};
        assign sum1 = {1'b0, a_i[g*BLOCK_W +: BLOCK_W]} + {1'b0, b_i[g*BLOCK_W +: BLOCK_W]}
                    + {{BLOCK_W{1'b0}}, 1'b1};

        assign sum_o[g*BLOCK_W +: BLOCK_W] = carry[g] ? sum1[BLOCK_W-1:0] : sum0[BLOCK_W-1:0];

        // The top block's carry-out is a modulo wrap and is detected by the caller.
        if (g < NBLK - 1) begin : g_carry
            assign carry[g+1] = carry[g] ? sum1[BLOCK_W] : sum0[BLOCK_W];
        end
    end

endmodule

// File: rtl/adder_accumulator.sv
// Sums a programmable-length stream of operands through the carry-select adder
// and presents the total plus a sticky wrap flag on a valid/ready handshake.
module adder_accumulator
    import adder_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_ovf,
    input  logic              i_ready
);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  accum_q, accum_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [DATA_W-1:0]  nextSum;

    carry_select_adder u_adder (
        .a_i   (accum_q),
        .b_i   (i_data),
        .sum_o (nextSum)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            accum_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            accum_q <= accum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // A zero-length job skips ACCUM; count is never 0 inside ACCUM, so it cannot underflow.
    always_comb begin
        state_d = state_q;
        accum_d = accum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    count_d = i_len;
                    accum_d = '0;
                    ovf_d   = 1'b0;
                    state_d = (i_len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (i_valid) begin
                    accum_d = nextSum;
                    ovf_d   = ovf_q | (nextSum < accum_q);
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy  = (state_q == ACCUM) || (state_q == DONE);
    assign o_ready = (state_q == ACCUM);
    assign o_valid = (state_q == DONE);
    assign o_sum   = accum_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed self-checking bench for adder_accumulator: hand-computed sums,
// carry/wrap boundaries, zero length, handshake stalls and mid-job reset.
module tb_adder_accumulator;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [7:0]  i_len;
    logic        o_busy;
    logic        i_valid;
    logic [31:0] i_data;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_sum;
    logic        o_ovf;
    logic        i_ready;

    int assertCount;
    int failCount;
    logic [31:0] beats [0:255];

    adder_accumulator dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_len   (i_len),
        .o_busy  (o_busy),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_sum   (o_sum),
        .o_ovf   (o_ovf),
        .i_ready (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Starts a job and feeds nBeats operands; with gaps, idle cycles are inserted
    // and a stray start with a different length is pulsed mid-job.
    task automatic applyStimulus(input int len, input int nBeats, input bit gaps);
        i_start = 1'b1;
        i_len   = 8'(len);
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 0; k < nBeats; k++) begin
            if (gaps) begin
                if (k == 1) begin
                    i_valid = 1'b0;
                    i_start = 1'b1;
                    i_len   = 8'd1;
                    @(negedge i_clk);
                    i_start = 1'b0;
                end
                repeat ($urandom_range(0, 2)) begin
                    i_valid = 1'b0;
                    i_data  = 32'hDEAD_BEEF;
                    @(negedge i_clk);
                end
            end
            checkOutput("ready_in_accum", {31'd0, o_ready}, 32'd1);
            i_valid = 1'b1;
            i_data  = beats[k];
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_data  = 32'h0;
    endtask

    // Checks the result presented in DONE, holds it for holdCycles, then accepts it.
    task automatic checkDone(input string tag, input logic [31:0] expSum, input bit expOvf,
                             input int holdCycles, input bit startOnAccept);
        checkOutput({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        checkOutput({tag, "_ready_low"}, {31'd0, o_ready}, 32'd0);
        checkOutput({tag, "_sum"}, o_sum, expSum);
        checkOutput({tag, "_ovf"}, {31'd0, o_ovf}, {31'd0, expOvf});
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge i_clk);
            checkOutput({tag, "_hold_valid"}, {31'd0, o_valid}, 32'd1);
            checkOutput({tag, "_hold_sum"}, o_sum, expSum);
            checkOutput({tag, "_hold_ovf"}, {31'd0, o_ovf}, {31'd0, expOvf});
        end
        i_ready = 1'b1;
        i_start = startOnAccept;
        i_len   = 8'd3;
        @(negedge i_clk);
        i_ready = 1'b0;
        i_start = 1'b0;
        checkOutput({tag, "_idle_valid"}, {31'd0, o_valid}, 32'd0);
        checkOutput({tag, "_idle_busy"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        assertCount = 0;
        failCount   = 0;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_len   = 8'd0;
        i_valid = 1'b0;
        i_data  = 32'h0;
        i_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("rst_ready", {31'd0, o_ready}, 32'd0);
        checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("rst_sum", o_sum, 32'd0);
        checkOutput("rst_ovf", {31'd0, o_ovf}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Basic sum; a start coincident with acceptance must be ignored.
        beats[0] = 32'd1; beats[1] = 32'd2; beats[2] = 32'd3;
        applyStimulus(3, 3, 1'b0);
        checkDone("basic", 32'd6, 1'b0, 0, 1'b1);
        @(negedge i_clk);
        checkOutput("start_on_accept_ignored", {31'd0, o_busy}, 32'd0);

        beats[0] = 32'h00FF_FFFF; beats[1] = 32'h0000_0001;
        applyStimulus(2, 2, 1'b0);
        checkDone("carry24", 32'h0100_0000, 1'b0, 0, 1'b0);

        beats[0] = 32'h7FFF_FFFF; beats[1] = 32'h0000_0001;
        applyStimulus(2, 2, 1'b0);
        checkDone("carry31", 32'h8000_0000, 1'b0, 0, 1'b0);

        beats[0] = 32'hFFFF_FFFF; beats[1] = 32'h0000_0002;
        applyStimulus(2, 2, 1'b0);
        checkDone("wrap", 32'h0000_0001, 1'b1, 1, 1'b0);

        beats[0] = 32'd5;
        applyStimulus(1, 1, 1'b0);
        checkDone("after_wrap", 32'd5, 1'b0, 0, 1'b0);

        beats[0] = 32'hFFFF_FFFF; beats[1] = 32'h0000_0002;
        applyStimulus(2, 2, 1'b0);
        checkDone("wrap2", 32'h0000_0001, 1'b1, 0, 1'b0);

        applyStimulus(0, 0, 1'b0);
        checkDone("zero_len", 32'd0, 1'b0, 0, 1'b0);

        beats[0] = 32'd10; beats[1] = 32'd20; beats[2] = 32'd30; beats[3] = 32'd40;
        applyStimulus(4, 4, 1'b1);
        checkDone("stress", 32'd100, 1'b0, 5, 1'b0);

        for (int k = 0; k < 255; k++) beats[k] = 32'd1;
        applyStimulus(255, 255, 1'b0);
        checkDone("max_len", 32'd255, 1'b0, 0, 1'b0);

        beats[0] = 32'd11; beats[1] = 32'd22;
        applyStimulus(4, 2, 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("midrst_ready", {31'd0, o_ready}, 32'd0);
        checkOutput("midrst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("midrst_sum", o_sum, 32'd0);
        checkOutput("midrst_ovf", {31'd0, o_ovf}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        beats[0] = 32'd7;
        applyStimulus(1, 1, 1'b0);
        checkDone("post_rst", 32'd7, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/adder_accumulator.md
Name: adder_accumulator

Overview:
- Sequential consumer of the 32-bit carry-select adder.
- Accepts a programmable-length stream of 32-bit unsigned operands over a valid/ready handshake and sums them into a running accumulator, one operand per cycle. The adder sees the accumulator on one input and the incoming operand on the other.
- Presents the final sum and a sticky wrap (overflow) flag on an output valid/ready handshake.

Parameters:
- DATA_W, 32, operand/accumulator width; fixed at 32 to match the adder datapath.
- LEN_W, 8, width of the operand-count input; max stream length is 2^LEN_W - 1.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  start pulse; sampled only in IDLE.
- i_len  input  LEN_W  number of operands to sum; sampled with i_start.
- o_busy  output  1  high in ACCUM and DONE.
- i_valid  input  1  operand valid.
- i_data  input  DATA_W  operand.
- o_ready  output  1  operand ready; high only in ACCUM.
- o_valid  output  1  result valid; high only in DONE.
- o_sum  output  DATA_W  registered accumulator value.
- o_ovf  output  1  sticky unsigned wrap flag for the current job.
- i_ready  input  1  downstream accepts result.

Behaviour:
- Clock and reset: single clock, i_clk. Reset is asynchronous and active-low on i_rst_n, and forces:
  - state = IDLE;
  - accumulator = 0, count = 0, o_ovf = 0;
  - o_busy = o_ready = o_valid = 0, o_sum = 0.
- Reset mid-job abandons the job immediately; no result is produced.
- States and transitions:
  - IDLE: on i_start=1:
    - count <= i_len; accumulator <= 0; ovf <= 0.
    - If i_len == 0, go to DONE, which presents sum 0 one cycle later.
    - Otherwise go to ACCUM.
  - ACCUM: o_ready = 1. A beat is accepted when i_valid & o_ready. On each accepted beat:
    - accumulator <= adder(accumulator, i_data), combinational in the same cycle;
    - ovf <= ovf | (new_sum < accumulator), i.e. unsigned wrap;
    - count <= count - 1.
    - If count == 1 on the accepted beat, go to DONE.
    - Cycles with i_valid = 0 leave all state unchanged.
  - DONE: o_valid = 1. o_sum and o_ovf are held stable while i_ready = 0. On o_valid & i_ready, go to IDLE.
- Latency: o_valid rises on the cycle after the final accepted beat. Peak throughput is one operand per cycle.
- Job overhead: at least 1 IDLE cycle between jobs. An i_start coincident with result acceptance is ignored; the start must be reasserted in IDLE.
- i_start outside IDLE is ignored; i_len is not re-sampled.
- i_data is ignored while o_ready = 0.
- Arithmetic: modulo 2^32, unsigned. The sum wraps; o_ovf records that at least one wrap occurred in this job. o_ovf is cleared only by a new start or by reset.
- o_sum always mirrors the accumulator register; it is meaningful only while o_valid = 1.
- Maximum job length: i_len = 2^LEN_W - 1 (255 at the default); count must not underflow.

Decomposition:
- Shared package adder_pkg holds:
  - DATA_W = 32;
  - the state typedef with 2-bit encodings IDLE = 2'b00, ACCUM = 2'b01, DONE = 2'b10, all others recovering to IDLE.
- One sub-module: the existing carry_select_adder, instantiated once as the datapath adder. Its inputs are the accumulator and i_data; its output is the next-sum.
- FSM, counter and ovf compare stay in adder_accumulator.

Test Plan:
- Basic sum: start, len=3; data 1, 2, 3 with i_valid held -> o_valid on cycle 4 after start, o_sum=6, o_ovf=0.
- Carry across 8-bit block boundaries: len=2; data 0x00FFFFFF, 0x00000001 -> o_sum=0x01000000. Then len=2; data 0x7FFFFFFF, 0x00000001 -> o_sum=0x80000000, o_ovf=0.
- Wrap: len=2; data 0xFFFFFFFF, 0x00000002 -> o_sum=0x00000001, o_ovf=1. The next job with len=1, data 5 -> o_sum=5, o_ovf=0.
- Zero length: start with len=0 -> o_ready never asserts; o_valid one cycle later with o_sum=0, o_ovf=0.
- Handshake stress: len=4; data 10, 20, 30, 40 with random i_valid gaps; i_start pulsed during ACCUM; i_ready low for 5 cycles in DONE -> o_sum=100 held stable throughout and the stray start is ignored. Return to IDLE on the cycle i_ready rises.
- Reset mid-job: len=4, 2 beats accepted, then i_rst_n low asynchronously -> all outputs 0 and state IDLE immediately. A new job with len=1, data 7 -> o_sum=7.
